// File: rtl/hazard_scoreboard_unit.sv
// Pending-write scoreboard with writeback shadow and ID-stage stall generation for long-latency ops.
// Optional HAZARD_PERF_EN adds saturating RAW/WAW and structural stall-cycle counters.
module hazard_scoreboard_unit #(
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned IDX_W           = 5,
    parameter int unsigned NUM_SRC         = 3,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned FWD_GAP         = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_SRC*IDX_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_fp,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic [IDX_W-1:0]         id_rd,
    input  logic                     id_rd_fp,
    input  logic                     id_rd_we,
    input  logic                     id_long,
    input  logic                     issue,
    input  logic                     idex_mem_read,
    input  logic [IDX_W-1:0]         idex_rd,
    input  logic                     idex_rd_fp,
    input  logic                     wb_valid,
    input  logic [IDX_W-1:0]         wb_rd,
    input  logic                     wb_fp,
    output logic                     stall_pc,
    output logic                     stall_ifid,
    output logic                     bubble_idex,
    output logic [NUM_REGS-1:0]      pending_int,
    output logic [NUM_REGS-1:0]      pending_fp,
    output logic [3:0]               outstanding,
    output logic                     sb_error,
    output logic [31:0]              perf_raw,
    output logic [31:0]              perf_struct
);

    localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] r_pend_int, r_pend_fp;
    logic [NUM_REGS-1:0] w_pend_int_d, w_pend_fp_d;
    logic [NUM_REGS-1:0] w_wb_int, w_wb_fp;
    logic [NUM_REGS-1:0] w_busy_int_raw, w_busy_fp, w_busy_int;
    logic [3:0]          r_out, w_out_d;
    logic                r_err;
    logic                w_inc, w_set, w_wb_pending, w_err;
    logic                w_raw, w_waw, w_lu, w_struct, w_other;

    always_comb begin
        w_wb_int = '0;
        w_wb_fp  = '0;
        if (wb_valid) begin
            if (wb_fp) w_wb_fp[wb_rd]  = 1'b1;
            else       w_wb_int[wb_rd] = 1'b1;
        end
    end

    generate
        if (FWD_GAP > 0) begin : g_shadow
            logic                r_sh_valid [FWD_GAP];
            logic                r_sh_fp    [FWD_GAP];
            logic [IDX_W-1:0]    r_sh_rd    [FWD_GAP];
            logic [NUM_REGS-1:0] w_sh_int, w_sh_fp;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < FWD_GAP; i++) begin
                        r_sh_valid[i] <= 1'b0;
                        r_sh_fp[i]    <= 1'b0;
                        r_sh_rd[i]    <= '0;
                    end
                end else begin
                    r_sh_valid[0] <= wb_valid;
                    r_sh_fp[0]    <= wb_fp;
                    r_sh_rd[0]    <= wb_rd;
                    for (int i = 1; i < FWD_GAP; i++) begin
                        r_sh_valid[i] <= r_sh_valid[i-1];
                        r_sh_fp[i]    <= r_sh_fp[i-1];
                        r_sh_rd[i]    <= r_sh_rd[i-1];
                    end
                end
            end

            always_comb begin
                w_sh_int = '0;
                w_sh_fp  = '0;
                for (int i = 0; i < FWD_GAP; i++) begin
                    if (r_sh_valid[i]) begin
                        if (r_sh_fp[i]) w_sh_fp[r_sh_rd[i]]  = 1'b1;
                        else            w_sh_int[r_sh_rd[i]] = 1'b1;
                    end
                end
            end

            assign w_busy_int_raw = r_pend_int | w_sh_int;
            assign w_busy_fp      = r_pend_fp | w_sh_fp;
        end else begin : g_no_shadow
            // Without a shadow, a register is forwardable in its own completion cycle.
            assign w_busy_int_raw = r_pend_int & ~w_wb_int;
            assign w_busy_fp      = r_pend_fp & ~w_wb_fp;
        end
    endgenerate

    assign w_busy_int = w_busy_int_raw & {{(NUM_REGS-1){1'b1}}, 1'b0};

    always_comb begin
        w_raw = 1'b0;
        w_lu  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            logic [IDX_W-1:0] src;
            src = id_rs[k*IDX_W +: IDX_W];
            if (id_rs_used[k]) begin
                if (id_rs_fp[k] ? w_busy_fp[src] : w_busy_int[src]) w_raw = 1'b1;
                if (idex_mem_read && (idex_rd_fp == id_rs_fp[k]) && (idex_rd == src) &&
                    (id_rs_fp[k] || (src != '0))) w_lu = 1'b1;
            end
        end
    end

    assign w_waw    = id_rd_we & (id_rd_fp ? w_busy_fp[id_rd] : w_busy_int[id_rd]);
    assign w_struct = id_long & (r_out == MaxOut) & ~wb_valid;
    assign w_other  = w_raw | w_waw | w_lu;

    assign stall_pc    = (w_other | w_struct) & reset_n;
    assign stall_ifid  = stall_pc;
    assign bubble_idex = stall_pc;

    assign w_inc        = issue & id_long;
    assign w_set        = w_inc & id_rd_we;
    assign w_wb_pending = wb_fp ? r_pend_fp[wb_rd] : r_pend_int[wb_rd];
    assign w_err        = (wb_valid & ~w_wb_pending) | (wb_valid & (r_out == 4'd0)) |
                          (w_inc & (r_out == MaxOut) & ~wb_valid);

    // Clear first so a same-cycle set of the same bit wins.
    always_comb begin
        w_pend_int_d = r_pend_int & ~w_wb_int;
        w_pend_fp_d  = r_pend_fp & ~w_wb_fp;
        if (w_set) begin
            if (id_rd_fp)             w_pend_fp_d[id_rd]  = 1'b1;
            else if (id_rd != '0)     w_pend_int_d[id_rd] = 1'b1;
        end
    end

    always_comb begin
        w_out_d = r_out;
        if (w_inc && !wb_valid && (r_out != MaxOut)) w_out_d = r_out + 4'd1;
        if (!w_inc && wb_valid && (r_out != 4'd0))   w_out_d = r_out - 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_int <= '0;
            r_pend_fp  <= '0;
            r_out      <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_pend_int <= w_pend_int_d;
            r_pend_fp  <= w_pend_fp_d;
            r_out      <= w_out_d;
            r_err      <= r_err | w_err;
        end
    end

    assign pending_int = r_pend_int;
    assign pending_fp  = r_pend_fp;
    assign outstanding = r_out;
    assign sb_error    = r_err;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_raw, r_perf_struct;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_raw    <= '0;
            r_perf_struct <= '0;
        end else begin
            if (w_other && (r_perf_raw != '1)) r_perf_raw <= r_perf_raw + 32'd1;
            if (w_struct && !w_other && (r_perf_struct != '1)) begin
                r_perf_struct <= r_perf_struct + 32'd1;
            end
        end
    end

    assign perf_raw    = r_perf_raw;
    assign perf_struct = r_perf_struct;
`else
    assign perf_raw    = '0;
    assign perf_struct = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: three instances (FWD_GAP 0/1/2) share stimulus and are checked
// every cycle against a register-level model, plus directed literal expectations.
module tb_hazard_scoreboard_unit;

    localparam int NR = 32;
    localparam int IW = 5;
    localparam int NS = 3;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NS*IW-1:0] id_rs;
    logic [NS-1:0]    id_rs_fp, id_rs_used;
    logic [IW-1:0]    id_rd, idex_rd, wb_rd;
    logic id_rd_fp, id_rd_we, id_long, issue, idex_mem_read, idex_rd_fp, wb_valid, wb_fp;

    logic          s_pc [3];
    logic          s_ifid [3];
    logic          s_bub [3];
    logic [NR-1:0] p_int [3];
    logic [NR-1:0] p_fp [3];
    logic [3:0]    outs [3];
    logic          err [3];
    logic [31:0]   praw [3];
    logic [31:0]   pstr [3];

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.FWD_GAP(0)) dut_g0 (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rs_fp(id_rs_fp), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_rd_we(id_rd_we), .id_long(id_long), .issue(issue),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .idex_rd_fp(idex_rd_fp),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_fp(wb_fp), .stall_pc(s_pc[0]),
        .stall_ifid(s_ifid[0]), .bubble_idex(s_bub[0]), .pending_int(p_int[0]),
        .pending_fp(p_fp[0]), .outstanding(outs[0]), .sb_error(err[0]), .perf_raw(praw[0]),
        .perf_struct(pstr[0]));

    hazard_scoreboard_unit dut (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rs_fp(id_rs_fp), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_rd_we(id_rd_we), .id_long(id_long), .issue(issue),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .idex_rd_fp(idex_rd_fp),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_fp(wb_fp), .stall_pc(s_pc[1]),
        .stall_ifid(s_ifid[1]), .bubble_idex(s_bub[1]), .pending_int(p_int[1]),
        .pending_fp(p_fp[1]), .outstanding(outs[1]), .sb_error(err[1]), .perf_raw(praw[1]),
        .perf_struct(pstr[1]));

    hazard_scoreboard_unit #(.FWD_GAP(2)) dut_g2 (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rs_fp(id_rs_fp), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_rd_we(id_rd_we), .id_long(id_long), .issue(issue),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .idex_rd_fp(idex_rd_fp),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_fp(wb_fp), .stall_pc(s_pc[2]),
        .stall_ifid(s_ifid[2]), .bubble_idex(s_bub[2]), .pending_int(p_int[2]),
        .pending_fp(p_fp[2]), .outstanding(outs[2]), .sb_error(err[2]), .perf_raw(praw[2]),
        .perf_struct(pstr[2]));

    // ---------------- model ----------------
    bit  m_pend [2][NR];
    int  m_out;
    bit  m_err;
    bit  m_hv [3];
    bit  m_hf [3];
    int  m_hr [3];
    longint m_praw, m_pstr;

    function automatic bit m_busy(input int g, input bit f, input int r);
        bit b;
        if (!f && r == 0) return 1'b0;
        if (g == 0) return m_pend[f][r] && !(wb_valid && wb_fp == f && int'(wb_rd) == r);
        b = m_pend[f][r];
        for (int i = 0; i < g; i++) if (m_hv[i] && m_hf[i] == f && m_hr[i] == r) b = 1'b1;
        return b;
    endfunction

    function automatic bit m_other(input int g);
        bit h = 1'b0;
        for (int k = 0; k < NS; k++) begin
            int src = int'(id_rs[k*IW +: IW]);
            if (id_rs_used[k]) begin
                if (m_busy(g, id_rs_fp[k], src)) h = 1'b1;
                if (idex_mem_read && idex_rd_fp == id_rs_fp[k] && int'(idex_rd) == src &&
                    (id_rs_fp[k] || src != 0)) h = 1'b1;
            end
        end
        if (id_rd_we && m_busy(g, id_rd_fp, int'(id_rd))) h = 1'b1;
        return h;
    endfunction

    function automatic bit m_struct();
        return id_long && m_out == MAXO && !wb_valid;
    endfunction

    function automatic bit m_stall(input int g);
        return reset_n && (m_other(g) || m_struct());
    endfunction

    function automatic logic [NR-1:0] m_vec(input bit f);
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = m_pend[f][r];
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NR; r++) begin
                m_pend[0][r] = 1'b0;
                m_pend[1][r] = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                m_hv[i] = 1'b0;
                m_hf[i] = 1'b0;
                m_hr[i] = 0;
            end
            m_out = 0;
            m_err = 1'b0;
            m_praw = 0;
            m_pstr = 0;
        end else begin
            bit o, s;
            o = m_other(1);
            s = m_struct();
            if (o && m_praw < 64'hffff_ffff) m_praw++;
            if (s && !o && m_pstr < 64'hffff_ffff) m_pstr++;
            if (wb_valid && (!m_pend[wb_fp][wb_rd] || m_out == 0)) m_err = 1'b1;
            if (issue && id_long && m_out == MAXO && !wb_valid) m_err = 1'b1;
            if (issue && id_long && !wb_valid && m_out < MAXO) m_out++;
            if (wb_valid && !(issue && id_long) && m_out > 0) m_out--;
            if (wb_valid) m_pend[wb_fp][wb_rd] = 1'b0;
            if (issue && id_long && id_rd_we && (id_rd_fp || id_rd != 0))
                m_pend[id_rd_fp][id_rd] = 1'b1;
            for (int i = 2; i > 0; i--) begin
                m_hv[i] = m_hv[i-1];
                m_hf[i] = m_hf[i-1];
                m_hr[i] = m_hr[i-1];
            end
            m_hv[0] = wb_valid;
            m_hf[0] = wb_fp;
            m_hr[0] = int'(wb_rd);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            check($sformatf("stall_pc_g%0d", g), 64'(s_pc[g]), 64'(m_stall(g)));
            check($sformatf("stall_ifid_g%0d", g), 64'(s_ifid[g]), 64'(m_stall(g)));
            check($sformatf("bubble_idex_g%0d", g), 64'(s_bub[g]), 64'(m_stall(g)));
        end
        check("pending_int", 64'(p_int[1]), 64'(m_vec(1'b0)));
        check("pending_fp", 64'(p_fp[1]), 64'(m_vec(1'b1)));
        check("outstanding", 64'(outs[1]), 64'(m_out));
        check("sb_error", 64'(err[1]), 64'(m_err));
`ifdef HAZARD_PERF_EN
        check("perf_raw", 64'(praw[1]), 64'(m_praw));
        check("perf_struct", 64'(pstr[1]), 64'(m_pstr));
`else
        check("perf_raw", 64'(praw[1]), 64'd0);
        check("perf_struct", 64'(pstr[1]), 64'd0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        id_rs = '0; id_rs_fp = '0; id_rs_used = '0;
        id_rd = '0; id_rd_fp = 1'b0; id_rd_we = 1'b0; id_long = 1'b0; issue = 1'b0;
        idex_mem_read = 1'b0; idex_rd = '0; idex_rd_fp = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_fp = 1'b0;
    endtask

    task automatic set_src(input int k, input int idx, input bit fp);
        id_rs[k*IW +: IW] = IW'(idx);
        id_rs_fp[k] = fp;
        id_rs_used[k] = 1'b1;
    endtask

    task automatic long_op(input int rd, input bit fp);
        issue = 1'b1; id_long = 1'b1; id_rd_we = 1'b1; id_rd = IW'(rd); id_rd_fp = fp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #12;
        check("rst_pending_int", 64'(p_int[1]), 64'd0);
        check("rst_outstanding", 64'(outs[1]), 64'd0);
        check("rst_stall", 64'(s_pc[1]), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Test 1: long MUL x5, dependent ADD, writeback at t4
        long_op(5, 1'b0);
        half(); check("t1_issue_nostall", 64'(s_pc[1]), 64'd0);
        tick();
        check("t1_pend5_set", 64'(p_int[1][5]), 64'd1);
        check("t1_out1", 64'(outs[1]), 64'd1);
        idle(); set_src(0, 5, 1'b0); id_rd = 5'd6; id_rd_we = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            half(); check($sformatf("t1_stall_t%0d", t), 64'(s_pc[1]), 64'd1);
            tick();
        end
        wb_valid = 1'b1; wb_rd = 5'd5;
        half();
        check("t1_t4_g1", 64'(s_pc[1]), 64'd1);
        check("t1_t4_g0", 64'(s_pc[0]), 64'd0);
        check("t1_t4_g2", 64'(s_pc[2]), 64'd1);
        tick(); wb_valid = 1'b0;
        check("t1_pend5_clr", 64'(p_int[1][5]), 64'd0);
        half();
        check("t1_t5_g1", 64'(s_pc[1]), 64'd1);
        check("t1_t5_g0", 64'(s_pc[0]), 64'd0);
        tick();
        half();
        check("t1_t6_g1", 64'(s_pc[1]), 64'd0);
        check("t1_t6_g2", 64'(s_pc[2]), 64'd1);
        tick();
        half(); check("t1_t7_g2", 64'(s_pc[2]), 64'd0);
        tick();
        idle(); tick();

        // Test 3: structural stall at MAX_OUTSTANDING
        for (int i = 0; i < 4; i++) begin
            idle(); long_op(10 + i, 1'b0); tick();
        end
        idle();
        check("t3_out4", 64'(outs[1]), 64'd4);
        id_long = 1'b1; id_rd = 5'd14; id_rd_we = 1'b1;
        half(); check("t3_struct_stall", 64'(s_pc[1]), 64'd1);
        tick();
        wb_valid = 1'b1; wb_rd = 5'd10; issue = 1'b1;
        half(); check("t3_wb_frees", 64'(s_pc[1]), 64'd0);
        tick(); idle();
        check("t3_out_stays4", 64'(outs[1]), 64'd4);
        check("t3_pend14", 64'(p_int[1][14]), 64'd1);
        check("t3_no_err", 64'(err[1]), 64'd0);
        for (int i = 11; i <= 14; i++) begin
            idle(); wb_valid = 1'b1; wb_rd = IW'(i); tick();
        end
        idle();
        check("t3_drained", 64'(outs[1]), 64'd0);
        tick();

        // Test 4: load-use
        idex_mem_read = 1'b1; idex_rd = 5'd3; idex_rd_fp = 1'b1; set_src(2, 3, 1'b1);
        half(); check("t4_fp_loaduse", 64'(s_pc[1]), 64'd1);
        tick();
        idex_rd_fp = 1'b0;
        half(); check("t4_file_mismatch", 64'(s_pc[1]), 64'd0);
        tick();
        idle(); idex_mem_read = 1'b1; idex_rd = 5'd0; set_src(0, 0, 1'b0);
        half(); check("t4_x0_nostall", 64'(s_pc[1]), 64'd0);
        tick();
        idle(); tick();

        // Test 5: set-wins and sticky error
        long_op(7, 1'b0); tick();
        long_op(7, 1'b0); wb_valid = 1'b1; wb_rd = 5'd7;
        tick(); idle();
        check("t5_pend7_setwins", 64'(p_int[1][7]), 64'd1);
        check("t5_out1", 64'(outs[1]), 64'd1);
        check("t5_err0", 64'(err[1]), 64'd0);
        wb_valid = 1'b1; wb_rd = 5'd9;
        tick(); idle();
        check("t5_err_set", 64'(err[1]), 64'd1);
        tick(); tick();
        check("t5_err_sticky", 64'(err[1]), 64'd1);
        long_op(2, 1'b1); tick();
        long_op(8, 1'b0); tick();
        idle();
        check("t5_pend_fp2", 64'(p_fp[1][2]), 64'd1);

        // Test 6: asynchronous reset mid-sequence
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_pend_int0", 64'(p_int[1]), 64'd0);
        check("t6_pend_fp0", 64'(p_fp[1]), 64'd0);
        check("t6_out0", 64'(outs[1]), 64'd0);
        check("t6_err0", 64'(err[1]), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        wb_valid = 1'b1; wb_rd = 5'd7;
        tick(); idle();
        check("t6_stale_wb_err", 64'(err[1]), 64'd1);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
